pkt_lane_buffer: RTL and testbench
==================================

# pkt_lane_buffer

Parametrised successor to the single-path packet buffer. It accepts an AXI4-Stream of IN_WIDTH-bit words and steers each whole packet into one of NUM_LANES internal lane FIFOs. Lanes are chosen round-robin among those with room for a maximum-size packet. Each lane drains as an independent OUT_WIDTH-bit stream with per-packet tlast, so parallel downstream parsers each receive complete, in-order packets.

## Interface
- IN_WIDTH, 64: input word width; multiple of OUT_WIDTH.
- OUT_WIDTH, 8: lane output width.
- NUM_LANES, 4: lane count; ≥2, power of two.
- LANE_DEPTH, 512: words (IN_WIDTH) per lane FIFO; power of two.
- MAX_PKT_WORDS, 190: maximum packet length in input words; must be ≤ LANE_DEPTH.
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- tdata_i  in  IN_WIDTH  input word.
- tvalid_i  in  1  input valid.
- tready_o  out  1  input ready.
- tlast_i  in  1  last word of packet.
- pkt_tdata_o[NUM_LANES]  out  OUT_WIDTH  lane data, MSB-first slice of stored word.
- pkt_tvalid_o[NUM_LANES]  out  1  lane valid.
- pkt_tlast_o[NUM_LANES]  out  1  final slice of packet.
- pkt_tready_i[NUM_LANES]  in  1  lane ready.
- drop_count_o  out  32  dropped-packet count; tied 0 when drop is compiled out.

## Operation
- Input FSM:
  - IDLE: a beat is accepted only if some lane is eligible. Eligible means free words ≥ MAX_PKT_WORDS.
  - On the first accepted beat, lock sel = first eligible lane at or after rr_ptr, then set rr_ptr = sel+1 (mod NUM_LANES).
  - IDLE→STEER when the first beat has tlast=0. A single-word packet stays in IDLE.
  - STEER: every accepted beat is written to lane sel together with its tlast. STEER→IDLE on an accepted tlast.
- Free space is evaluated only at packet start; packets are never split across lanes.
- A packet longer than MAX_PKT_WORDS is unsupported.
- Each lane FIFO stores {tlast, word}. Free count = LANE_DEPTH − occupancy, where occupancy is a log2(LANE_DEPTH)+1-bit counter. Pointers wrap naturally modulo LANE_DEPTH.
- Lane read side:
  - A RATIO = IN_WIDTH/OUT_WIDTH slice counter emits slices MSB-first.
  - A stored word is popped when slice RATIO−1 handshakes.
  - pkt_tlast_o = stored tlast AND slice counter = RATIO−1.
  - All bytes of the last word are treated as valid (no tkeep).
- Same-cycle write and read on one lane: occupancy is unchanged and the free count stays correct.
- Lanes are fully independent. A stalled lane only removes itself from eligibility.

## Timing
- Reset values: tready_o=0; all pkt_tvalid_o=0 and pkt_tlast_o=0; pkt_tdata_o=0; drop_count_o=0; rr_ptr=0; FSM=IDLE; all FIFOs empty.
- tready_o comes from registers only:
  - IDLE: tready_o = OR of registered eligibility.
  - STEER: tready_o = 1.
  - DROP: tready_o = 1.
- Eligibility is registered from occupancy, so it is 1 cycle stale. MAX_PKT_WORDS headroom absorbs this.
- Latency: a beat accepted in cycle N gives first slice pkt_tvalid_o in cycle N+2, with registered FIFO read data.
- Throughput per lane: one slice per cycle while pkt_tready_i=1, with no bubbles between words or packets.
- Data and tlast are held stable while valid=1 and ready=0.
- Reset mid-packet: the partial packet is discarded, FIFOs are flushed, and outputs return to their reset values on the next cycle.

## Configuration
- PKT_LANE_BUFFER_DROP_EN defined:
  - If no lane is eligible at packet start, the FSM enters DROP with tready_o=1.
  - All beats are discarded through tlast, then the FSM returns to IDLE.
  - drop_count_o increments once per dropped packet and saturates at 2^32−1.
- Undefined: no DROP state; the input backpressures (tready_o=0) until a lane becomes eligible; drop_count_o=0.

## Structure
- pkt_lane_buffer_pkg holds:
  - lane_idx_t;
  - fsm enum in_state_t {IDLE, STEER, DROP};
  - a function for the first eligible lane at or after a pointer.
- Sub-module pkt_lane_fifo: one lane containing storage, occupancy counter, free output and width down-converter. It is instantiated NUM_LANES times under generate.
- Top level: input FSM, round-robin pointer, drop counter.

## Test plan
- Reset then 4 single-lane packets of 10 words, all lanes ready → packets land on lanes 0,1,2,3; each lane emits 80 bytes MSB-first, with tlast on byte 80 only.
- Word 0x0011223344556677 accepted at cycle N → lane shows 0x00 at N+2, then 0x11…0x77 on consecutive cycles.
- Lane 1 pkt_tready_i=0 and filled until free < 190 → the next packet skips lane 1 (0→2); rr_ptr still advances.
- All lanes blocked, macro undefined → tready_o=0 until one lane drains ≥190 words free; then the packet goes there intact.
- All lanes blocked, PKT_LANE_BUFFER_DROP_EN defined, 3 packets sent → drop_count_o=3, nothing written, tready_o stays 1.
- Assert rst_i in mid-packet, then send new packet → no residue on any lane; the new packet goes to lane 0.

Source files
------------

// File: rtl/pkt_lane_buffer_pkg.sv
// Shared types and the round-robin lane-selection helper for pkt_lane_buffer.
package pkt_lane_buffer_pkg;

  localparam int unsigned MAX_LANES  = 16;
  localparam int unsigned LANE_IDX_W = $clog2(MAX_LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    STEER,
    DROP
  } in_state_t;

  // Smallest rotational offset from ptr wins; returns ptr when nothing is eligible.
  function automatic lane_idx_t first_eligible(
    input logic [MAX_LANES-1:0] elig,
    input lane_idx_t            ptr,
    input int unsigned          num_lanes
  );
    lane_idx_t result;
    lane_idx_t idx;
    result = ptr;
    for (int k = MAX_LANES - 1; k >= 0; k--) begin
      if (k < int'(num_lanes)) begin
        idx = lane_idx_t'((int'(ptr) + k) % int'(num_lanes));
        if (elig[idx]) result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pkt_lane_fifo.sv
// One lane of pkt_lane_buffer: {tlast, word} storage, occupancy/free tracking and an
// MSB-first width down-converter fed from a registered memory read.
module pkt_lane_fifo #(
  parameter int unsigned IN_WIDTH   = 64,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned LANE_DEPTH = 512
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en,
  input  logic [IN_WIDTH-1:0]         wr_data,
  input  logic                        wr_last,
  output logic [$clog2(LANE_DEPTH):0] free,
  output logic [OUT_WIDTH-1:0]        tdata,
  output logic                        tvalid,
  output logic                        tlast,
  input  logic                        tready
);
  localparam int unsigned RATIO   = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned PTR_W   = $clog2(LANE_DEPTH);
  localparam int unsigned SLICE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [IN_WIDTH:0]    mem [LANE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]       occ_reg;
  logic [IN_WIDTH-1:0]  word_reg;
  logic                 last_reg, valid_reg;
  logic [SLICE_W-1:0]   slice_reg;
  logic [OUT_WIDTH-1:0] slices [RATIO];
  logic                 slice_end, load;

  assign slice_end = (slice_reg == SLICE_W'(RATIO - 1));
  // Refill the output word when it is empty or its final slice is leaving, so words run back to back.
  assign load = (occ_reg != '0) && (!valid_reg || (tready && slice_end));
  assign free = (PTR_W + 1)'(LANE_DEPTH) - occ_reg;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_reg] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      word_reg   <= '0;
      last_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      slice_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (load) begin
        {last_reg, word_reg} <= mem[rd_ptr_reg];
        rd_ptr_reg           <= rd_ptr_reg + PTR_W'(1);
        valid_reg            <= 1'b1;
        slice_reg            <= '0;
      end else if (valid_reg && tready) begin
        if (slice_end) begin
          valid_reg <= 1'b0;
          slice_reg <= '0;
        end else begin
          slice_reg <= slice_reg + SLICE_W'(1);
        end
      end
      occ_reg <= occ_reg + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(load);
    end
  end

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign slices[gi] = word_reg[IN_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
  end

  assign tdata  = slices[slice_reg];
  assign tvalid = valid_reg;
  assign tlast  = valid_reg && last_reg && slice_end;

endmodule

// File: rtl/pkt_lane_buffer.sv
// Steers whole AXI4-Stream packets round-robin into NUM_LANES lane FIFOs (up to MAX_LANES).
// Define PKT_LANE_BUFFER_DROP_EN to discard packets when no lane has room instead of stalling.
module pkt_lane_buffer
  import pkt_lane_buffer_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 64,
  parameter int unsigned OUT_WIDTH     = 8,
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned LANE_DEPTH    = 512,
  parameter int unsigned MAX_PKT_WORDS = 190
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  tdata_i,
  input  logic                 tvalid_i,
  output logic                 tready_o,
  input  logic                 tlast_i,
  output logic [OUT_WIDTH-1:0] pkt_tdata_o  [NUM_LANES],
  output logic                 pkt_tvalid_o [NUM_LANES],
  output logic                 pkt_tlast_o  [NUM_LANES],
  input  logic                 pkt_tready_i [NUM_LANES],
  output logic [31:0]          drop_count_o
);
  localparam int unsigned FREE_W = $clog2(LANE_DEPTH) + 1;

  in_state_t            state_reg;
  lane_idx_t            sel_reg, rr_ptr_reg, pick, rr_ptr_next;
  logic [NUM_LANES-1:0] elig_reg, wr_en;
  logic [FREE_W-1:0]    free [NUM_LANES];
  logic [MAX_LANES-1:0] elig_ext;
  logic                 run_reg, any_elig, accept, start_ok;

  assign elig_ext    = MAX_LANES'(elig_reg);
  assign any_elig    = |elig_reg;
  assign pick        = first_eligible(elig_ext, rr_ptr_reg, NUM_LANES);
  assign rr_ptr_next = lane_idx_t'((int'(pick) + 1) % int'(NUM_LANES));
  assign accept      = tvalid_i && tready_o;
  assign start_ok    = accept && (state_reg == IDLE) && any_elig;

`ifdef PKT_LANE_BUFFER_DROP_EN
  // Every state takes data: a start with no room is swallowed by DROP.
  assign tready_o = run_reg;
`else
  assign tready_o = run_reg && ((state_reg != IDLE) || any_elig);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      rr_ptr_reg <= '0;
      run_reg    <= 1'b0;
      elig_reg   <= '0;
    end else begin
      run_reg <= 1'b1;
      for (int l = 0; l < int'(NUM_LANES); l++) begin
        elig_reg[l] <= (free[l] >= FREE_W'(MAX_PKT_WORDS));
      end
      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (any_elig) begin
              sel_reg    <= pick;
              rr_ptr_reg <= rr_ptr_next;
              if (!tlast_i) state_reg <= STEER;
            end
`ifdef PKT_LANE_BUFFER_DROP_EN
            else if (!tlast_i) begin
              state_reg <= DROP;
            end
`endif
          end
          STEER:   if (tlast_i) state_reg <= IDLE;
          DROP:    if (tlast_i) state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef PKT_LANE_BUFFER_DROP_EN
  logic [31:0] drop_cnt_reg;

  // Counted on the first beat of a refused packet, so each drop counts once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_reg <= '0;
    end else if (accept && (state_reg == IDLE) && !any_elig && (drop_cnt_reg != 32'hFFFF_FFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 32'd1;
    end
  end

  assign drop_count_o = drop_cnt_reg;
`else
  assign drop_count_o = '0;
`endif

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign wr_en[gi] = (start_ok && (pick == lane_idx_t'(gi))) ||
                       (accept && (state_reg == STEER) && (sel_reg == lane_idx_t'(gi)));

    pkt_lane_fifo #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .LANE_DEPTH(LANE_DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_en  (wr_en[gi]),
      .wr_data(tdata_i),
      .wr_last(tlast_i),
      .free   (free[gi]),
      .tdata  (pkt_tdata_o[gi]),
      .tvalid (pkt_tvalid_o[gi]),
      .tlast  (pkt_tlast_o[gi]),
      .tready (pkt_tready_i[gi])
    );
  end

endmodule

// File: tb/tb_pkt_lane_buffer.sv
// Scoreboard bench for pkt_lane_buffer: per-lane expected byte queues filled by a packet-level
// model at input acceptance, drained by an independent output monitor.
`timescale 1ns/1ps
module tb_pkt_lane_buffer;
  localparam int IN_W   = 64;
  localparam int OUT_W  = 8;
  localparam int NL     = 4;
  localparam int DEPTH  = 512;
  localparam int MAXW   = 190;
  localparam int RATIO  = IN_W / OUT_W;
  localparam int ELIG_LIMIT = DEPTH - MAXW + 1;
  localparam int ROOM_LIMIT = DEPTH - MAXW - 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IN_W-1:0] tdata = '0;
  logic            tvalid = 1'b0;
  logic            tlast = 1'b0;
  logic            tready;
  logic [OUT_W-1:0] l_data  [NL];
  logic             l_valid [NL];
  logic             l_last  [NL];
  logic             l_ready [NL];
  logic [31:0]      drop_count;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q [NL][$];
  int rr_m = 0;
  int drop_exp = 0;
  int lane_mode [NL];
  int cur_lane = 0;
  bit cur_drop = 0;

  logic [OUT_W-1:0] hold_d [NL];
  logic             hold_l [NL];
  bit               hold_v [NL];
  int               pkt_bytes [NL];

  pkt_lane_buffer #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .NUM_LANES(NL),
    .LANE_DEPTH(DEPTH), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .tdata_i(tdata), .tvalid_i(tvalid), .tready_o(tready), .tlast_i(tlast),
    .pkt_tdata_o(l_data), .pkt_tvalid_o(l_valid), .pkt_tlast_o(l_last),
    .pkt_tready_i(l_ready), .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int out_words(input int l);
    return (exp_q[l].size() + RATIO - 1) / RATIO;
  endfunction

  // A lane takes a packet when its undelivered backlog leaves room for a maximum-size packet.
  function automatic int pick_lane();
    for (int k = 0; k < NL; k++) begin
      int l;
      l = (rr_m + k) % NL;
      if (out_words(l) <= ELIG_LIMIT) return l;
    end
    return -1;
  endfunction

  // Lane ready drivers: 0 = stalled, 1 = always ready, 2 = random.
  initial begin
    for (int l = 0; l < NL; l++) begin
      l_ready[l] = 1'b0;
      lane_mode[l] = 1;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
        if (lane_mode[l] == 0) l_ready[l] = 1'b0;
        else if (lane_mode[l] == 1) l_ready[l] = 1'b1;
        else l_ready[l] = ($urandom_range(3) != 0);
      end
    end
  end

  // Output monitor: pops the scoreboard on every lane handshake.
  initial begin
    logic [8:0] e;
    for (int l = 0; l < NL; l++) begin
      hold_v[l] = 0;
      pkt_bytes[l] = 0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (rst) begin
          hold_v[l] = 0;
          pkt_bytes[l] = 0;
        end else begin
          if (hold_v[l]) begin
            check($sformatf("lane%0d_hold_valid", l), 64'(l_valid[l]), 64'd1);
            check($sformatf("lane%0d_hold_data", l), 64'(l_data[l]), 64'(hold_d[l]));
            check($sformatf("lane%0d_hold_last", l), 64'(l_last[l]), 64'(hold_l[l]));
          end
          hold_v[l] = 0;
          if (l_valid[l] && l_ready[l]) begin
            if (exp_q[l].size() == 0) begin
              total++;
              bad++;
              $display("FAIL lane%0d_unexpected: got byte %0h, expected no output", l, l_data[l]);
            end else begin
              e = exp_q[l].pop_front();
              check($sformatf("lane%0d_data", l), 64'(l_data[l]), 64'(e[7:0]));
              check($sformatf("lane%0d_last", l), 64'(l_last[l]), 64'(e[8]));
              pkt_bytes[l]++;
              if (e[8]) begin
                $display("lane %0d: packet of %0d bytes delivered", l, pkt_bytes[l]);
                pkt_bytes[l] = 0;
              end
            end
          end else if (l_valid[l]) begin
            hold_v[l] = 1;
            hold_d[l] = l_data[l];
            hold_l[l] = l_last[l];
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One input beat; the model decides the packet's lane at its first accepted beat.
  task automatic beat(input logic [IN_W-1:0] w, input bit last, input bit first);
    int waited;
    bit lb;
    waited = 0;
    tdata = w;
    tlast = last;
    tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (tready) break;
      waited++;
      if (waited > 6000) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: tready=0 for %0d cycles, expected 1", waited);
        break;
      end
    end
    if (tready) begin
      if (first) begin
        cur_lane = pick_lane();
        cur_drop = 0;
        if (cur_lane < 0) begin
          cur_drop = 1;
`ifdef PKT_LANE_BUFFER_DROP_EN
          drop_exp++;
`else
          total++;
          bad++;
          $display("FAIL accept_no_lane: got tready=1, expected 0 (no lane has room)");
`endif
        end else begin
          rr_m = (cur_lane + 1) % NL;
        end
      end
      if (!cur_drop) begin
        for (int s = 0; s < RATIO; s++) begin
          lb = last && (s == RATIO - 1);
          exp_q[cur_lane].push_back({lb, w[IN_W-1-s*OUT_W -: OUT_W]});
        end
      end
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit gaps, input bit use_first, input logic [IN_W-1:0] first_w);
    logic [IN_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = (i == 0 && use_first) ? first_w : {$urandom, $urandom};
      beat(w, i == n - 1, i == 0);
      if (gaps && $urandom_range(3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic drain(input int budget);
    int n;
    bit empty;
    n = 0;
    forever begin
      empty = 1;
      for (int l = 0; l < NL; l++) if (exp_q[l].size() != 0) empty = 0;
      if (empty) break;
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: bytes still pending after %0d cycles, expected none", n);
        break;
      end
      idle(1);
      n++;
    end
    idle(4);
  endtask

  task automatic wait_room();
    int n;
    bit ok;
    n = 0;
    forever begin
      ok = 1;
      for (int l = 0; l < NL; l++) if (out_words(l) > ROOM_LIMIT) ok = 0;
      if (ok) break;
      if (n >= 20000) begin
        total++;
        bad++;
        $display("FAIL room_timeout: lanes still full after %0d cycles, expected room", n);
        break;
      end
      idle(1);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < NL; l++) exp_q[l].delete();
    rr_m = 0;
    drop_exp = 0;
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("rst_lane%0d_valid", l), 64'(l_valid[l]), 64'd0);
      check($sformatf("rst_lane%0d_last", l), 64'(l_last[l]), 64'd0);
      check($sformatf("rst_lane%0d_data", l), 64'(l_data[l]), 64'd0);
    end
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [IN_W-1:0] hold_w;
    int len;
    do_reset();

    // Four 10-word packets with every lane ready land on lanes 0..3.
    for (int p = 0; p < 4; p++) send_pkt(10, 0, 0, '0);
    drain(4000);

    // Latency and MSB-first slicing on lane 0.
    beat(64'h0011223344556677, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_n1_valid", 64'(l_valid[0]), 64'd0);
    @(negedge clk);
    check("lat_n2_valid", 64'(l_valid[0]), 64'd1);
    check("lat_n2_data", 64'(l_data[0]), 64'h00);
    for (int k = 1; k < RATIO; k++) begin
      @(negedge clk);
      check($sformatf("lat_slice%0d_valid", k), 64'(l_valid[0]), 64'd1);
      check($sformatf("lat_slice%0d_data", k), 64'(l_data[0]), 64'(8'h11 * k));
    end
    drain(4000);

    // Stalled lane 1 fills past the headroom and is then skipped.
    lane_mode[1] = 0;
    send_pkt(MAXW, 0, 0, '0);
    for (int p = 0; p < 3; p++) send_pkt(5, 0, 0, '0);
    send_pkt(MAXW, 0, 0, '0);
    for (int p = 0; p < 5; p++) send_pkt(5, 0, 0, '0);
    lane_mode[1] = 2;
    drain(12000);

    // All lanes stalled and filled until none has room.
    for (int l = 0; l < NL; l++) lane_mode[l] = 0;
    for (int p = 0; p < 2 * NL; p++) send_pkt(170, 0, 0, '0);
`ifdef PKT_LANE_BUFFER_DROP_EN
    for (int p = 0; p < 3; p++) send_pkt(6, 0, 0, '0);
    @(negedge clk);
    check("drop_tready", 64'(tready), 64'd1);
    check("drop_count", 64'(drop_count), 64'(drop_exp));
`else
    hold_w = {$urandom, $urandom};
    tdata = hold_w;
    tlast = 1'b0;
    tvalid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("blocked_tready", 64'(tready), 64'(pick_lane() >= 0));
    end
    lane_mode[2] = 1;
    send_pkt(6, 0, 1, hold_w);
`endif
    for (int l = 0; l < NL; l++) lane_mode[l] = 2;
    drain(12000);

    // Reset in the middle of a packet leaves no residue; the next packet goes to lane 0.
    for (int l = 0; l < NL; l++) lane_mode[l] = 0;
    for (int i = 0; i < 5; i++) beat({$urandom, $urandom}, 1'b0, i == 0);
    do_reset();
    for (int l = 0; l < NL; l++) lane_mode[l] = 1;
    send_pkt(12, 0, 0, '0);
    drain(4000);

    // Randomised traffic with random lane backpressure.
    for (int l = 0; l < NL; l++) lane_mode[l] = 2;
    for (int p = 0; p < 24; p++) begin
      len = ($urandom_range(9) == 0) ? MAXW : int'($urandom_range(1, 40));
      wait_room();
      send_pkt(len, 1, 0, '0);
    end
    drain(20000);

    check("final_drop_count", 64'(drop_count), 64'(drop_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
